// File: rtl/postadder_pkg.sv
// Shared definitions for the Fp2 pre-adder / post-adder pair.
//   - redundant_poly_L3: three signed coefficients, value = sum c[k] * 2^(RADIX*k) (mod p).
//     Coefficients are never carried or reduced. Small negative values simply stay as
//     two's-complement coefficients until a later reduction stage.
//   - BN254_P: the field modulus used when a redundant value is finally reduced.
//   - PA_MODE_*: combination-mode encodings shared with the pre-adder.
//   - pa_term_e / pa_last_term: term-position states and the last term of a group for each mode.
package postadder_pkg;

  localparam int NCOEF = 3;
  localparam int CW    = 96;
  localparam int RADIX = 86;

  localparam logic [255:0] BN254_P =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  typedef logic [NCOEF-1:0][CW-1:0] redundant_poly_L3;

  localparam logic [1:0] PA_MODE_PASS = 2'b00;
  localparam logic [1:0] PA_MODE_KARA = 2'b01;
  localparam logic [1:0] PA_MODE_SQR  = 2'b10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } pa_term_e;

  // Encoding 11 is unused and behaves like pass-through.
  function automatic pa_term_e pa_last_term(input logic [1:0] m);
    case (m)
      PA_MODE_KARA: pa_last_term = T2;
      PA_MODE_SQR:  pa_last_term = T1;
      default:      pa_last_term = T0;
    endcase
  endfunction

endpackage

// File: rtl/poly_adder_L3_L3.sv
// Coefficient-wise adder/subtractor on redundant_poly_L3 operands.
// The result stays redundant: each coefficient wraps in its own CW bits, with no carry
// between coefficients and no modular reduction.
// Only the combinational form (LATENCY = 0) is implemented.
// Ports:
//   i_a, i_b  operands
//   i_sub     1: o_sum = i_a - i_b, 0: o_sum = i_a + i_b
//   o_sum     result
module poly_adder_L3_L3
  import postadder_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  redundant_poly_L3 i_a,
  input  redundant_poly_L3 i_b,
  input  logic             i_sub,
  output redundant_poly_L3 o_sum
);

  if (LATENCY != 0) begin : g_bad_latency
    $error("poly_adder_L3_L3: only LATENCY = 0 is implemented");
  end

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < NCOEF; k++) begin
      o_sum[k] = i_sub ? (i_a[k] - i_b[k]) : (i_a[k] + i_b[k]);
    end
  end

endmodule

// File: rtl/postadder.sv
// Karatsuba post-combination stage for Fp2 products.
// Takes the interleaved multiplier product stream, keeps per-thread partial products,
// and emits one registered (c0, c1) result for every beat of a group's final term.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   P, in_valid       product beat and its qualifier
//   mode              00 pass, 01 Karatsuba, 10 squaring (latched on the group's first beat)
//   Z0, Z1            result c0 / c1 (redundant form, held while out_valid = 0)
//   out_valid         result valid strobe
//   out_thread        thread index of the current result
//
// Term FSM (r_term, advances once every thread has delivered its beat for the term)
//   state | meaning
//   T0    | first term: pass emits P; mul/sqr stores d <= P
//   T1    | mul: d <= d - P, s <= d + P;  sqr: emit c0 = d, c1 = P + P
//   T2    | mul only: emit c0 = d, c1 = P - s
module postadder
  import postadder_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  redundant_poly_L3 P,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  output redundant_poly_L3 Z0,
  output redundant_poly_L3 Z1,
  output logic             out_valid,
  output logic [1:0]       out_thread
);

  localparam int         TW       = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam logic [1:0] THR_LAST = 2'(THREADS - 1);

  logic [1:0]       r_thr_cnt;
  pa_term_e         r_term;
  logic [1:0]       r_mode_q;
  redundant_poly_L3 r_d [THREADS];
  redundant_poly_L3 r_s [THREADS];
  redundant_poly_L3 r_z0;
  redundant_poly_L3 r_z1;
  logic             r_out_valid;
  logic [1:0]       r_out_thread;

  logic             w_first;
  logic [1:0]       w_mode;
  pa_term_e         w_last;
  logic             w_final;
  logic [TW-1:0]    w_idx;
  redundant_poly_L3 w_d;
  redundant_poly_L3 w_s;
  redundant_poly_L3 w_add0_a;
  redundant_poly_L3 w_sub0;
  redundant_poly_L3 w_add0;
  redundant_poly_L3 w_sub1;

  // The mode input only counts on the group's first beat; the rest of the group uses
  // the latched copy, so mid-group changes on the mode pins are ignored.
  assign w_first = (r_thr_cnt == 2'd0) && (r_term == T0);
  assign w_mode  = w_first ? mode : r_mode_q;
  assign w_last  = pa_last_term(w_mode);
  assign w_final = (r_term == w_last);

  assign w_idx   = r_thr_cnt[TW-1:0];
  assign w_d     = r_d[w_idx];
  assign w_s     = r_s[w_idx];

  // Squaring reuses add0 to form 2*a0*a1 = P + P.
  assign w_add0_a = (w_mode == PA_MODE_SQR) ? P : w_d;

  poly_adder_L3_L3 #(.LATENCY(0)) u_sub0 (
    .i_a   (w_d),
    .i_b   (P),
    .i_sub (1'b1),
    .o_sum (w_sub0)
  );

  poly_adder_L3_L3 #(.LATENCY(0)) u_add0 (
    .i_a   (w_add0_a),
    .i_b   (P),
    .i_sub (1'b0),
    .o_sum (w_add0)
  );

  poly_adder_L3_L3 #(.LATENCY(0)) u_sub1 (
    .i_a   (P),
    .i_b   (w_s),
    .i_sub (1'b1),
    .o_sum (w_sub1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_thr_cnt    <= '0;
      r_term       <= T0;
      r_mode_q     <= PA_MODE_PASS;
      r_z0         <= '0;
      r_z1         <= '0;
      r_out_valid  <= 1'b0;
      r_out_thread <= '0;
      for (int t = 0; t < THREADS; t++) begin
        r_d[t] <= '0;
        r_s[t] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        if (w_first) begin
          r_mode_q <= mode;
        end

        if (r_thr_cnt == THR_LAST) begin
          r_thr_cnt <= '0;
          if (w_final) begin
            r_term <= T0;
          end else if (r_term == T0) begin
            r_term <= T1;
          end else begin
            r_term <= T2;
          end
        end else begin
          r_thr_cnt <= r_thr_cnt + 2'd1;
        end

        case (r_term)
          T0: begin
            if ((w_mode == PA_MODE_KARA) || (w_mode == PA_MODE_SQR)) begin
              r_d[w_idx] <= P;
            end
          end
          T1: begin
            if (w_mode == PA_MODE_KARA) begin
              r_d[w_idx] <= w_sub0;
              r_s[w_idx] <= w_add0;
            end
          end
          default: ;
        endcase

        if (w_final) begin
          r_out_valid  <= 1'b1;
          r_out_thread <= r_thr_cnt;
          case (w_mode)
            PA_MODE_KARA: begin
              r_z0 <= w_d;
              r_z1 <= w_sub1;
            end
            PA_MODE_SQR: begin
              r_z0 <= w_d;
              r_z1 <= w_add0;
            end
            default: begin
              r_z0 <= P;
              r_z1 <= '0;
            end
          endcase
        end
      end
    end
  end

  assign Z0         = r_z0;
  assign Z1         = r_z1;
  assign out_valid  = r_out_valid;
  assign out_thread = r_out_thread;

endmodule
